axis64_pkt_rr_arbiter: RTL

Packet-granular round-robin arbiter that shares the single 64-bit AXI-Stream to_net egress of the KVS design between NR_SRC requesters, such as the KVS response path and control/management responders. Grant is held from a packet's first beat until its tlast beat, so packets never interleave. Sits in the 390 MHz network domain, directly in front of the to_net interface.

---
 rtl/kvs_axis_pkg.sv | 13 +
 rtl/rr_pick.sv | 27 ++
 rtl/axis64_pkt_rr_arbiter.sv | 124 ++++++++++++
 3 files changed

// File: rtl/kvs_axis_pkg.sv
// Shared AXI-Stream widths and arbiter state encoding for the KVS network path.
package kvs_axis_pkg;

    localparam int AXIS_DATA_W = 64;
    localparam int AXIS_KEEP_W = 8;
    localparam int AXIS_USER_W = 64;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } arb_state_e;

endpackage

// File: rtl/rr_pick.sv
// Rotating priority encoder: first requester after 'last', wrapping modulo NR_SRC.
module rr_pick #(
    parameter int NR_SRC = 2,
    parameter int IDX_W  = $clog2(NR_SRC)
) (
    input  logic [NR_SRC-1:0] req,
    input  logic [IDX_W-1:0]  last,
    output logic [IDX_W-1:0]  pick,
    output logic              pick_valid
);

    // Walk offsets from farthest to nearest so the nearest requester is kept.
    always_comb begin
        logic [IDX_W-1:0] idx;
        idx        = '0;
        pick       = '0;
        pick_valid = 1'b0;
        for (int off = NR_SRC; off >= 1; off--) begin
            idx = IDX_W'((int'(last) + off) % NR_SRC);
            if (req[idx]) begin
                pick       = idx;
                pick_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/axis64_pkt_rr_arbiter.sv
// Packet-granular round-robin arbiter onto the 64-bit to_net AXI-Stream.
// The grant is held from the first beat to the tlast beat, so packets never
// interleave; a 1-cycle bubble follows every packet.
// Optional build macro: ARB_PKT_STATS_EN adds per-source packet counters and
// an output stall counter.
module axis64_pkt_rr_arbiter
    import kvs_axis_pkg::*;
#(
    parameter  int NR_SRC = 2,
    parameter  int DATA_W = AXIS_DATA_W,
    parameter  int USER_W = AXIS_USER_W,
    localparam int KEEP_W = DATA_W / 8,
    localparam int GID_W  = $clog2(NR_SRC)
) (
    input  logic                     clk_390,
    input  logic                     clk_390_rst_n,
    input  logic                     arb_enable,
    input  logic [NR_SRC*DATA_W-1:0] s_tdata,
    input  logic [NR_SRC*KEEP_W-1:0] s_tkeep,
    input  logic [NR_SRC*USER_W-1:0] s_tuser,
    input  logic [NR_SRC-1:0]        s_tlast,
    input  logic [NR_SRC-1:0]        s_tvalid,
    output logic [NR_SRC-1:0]        s_tready,
    output logic [DATA_W-1:0]        m_tdata,
    output logic [KEEP_W-1:0]        m_tkeep,
    output logic [USER_W-1:0]        m_tuser,
    output logic                     m_tlast,
    output logic                     m_tvalid,
    input  logic                     m_tready,
    output logic [GID_W-1:0]         grant_id,
    output logic                     busy
`ifdef ARB_PKT_STATS_EN
    ,
    output logic [NR_SRC*32-1:0]     pkt_cnt,
    output logic [31:0]              stall_cnt
`endif
);

    // Packed views share the flat bus layout: source i at [i*W +: W].
    logic [NR_SRC-1:0][DATA_W-1:0] src_data;
    logic [NR_SRC-1:0][KEEP_W-1:0] src_keep;
    logic [NR_SRC-1:0][USER_W-1:0] src_user;

    assign src_data = s_tdata;
    assign src_keep = s_tkeep;
    assign src_user = s_tuser;

    arb_state_e       state_q, state_d;
    logic [GID_W-1:0] grant_q, last_q, pick;
    logic             pick_valid, grant_fire;

    rr_pick #(.NR_SRC(NR_SRC), .IDX_W(GID_W)) u_pick (
        .req       (s_tvalid),
        .last      (last_q),
        .pick      (pick),
        .pick_valid(pick_valid)
    );

    assign grant_fire = (state_q == ARB_IDLE) && arb_enable && pick_valid;
    assign busy       = (state_q == ARB_BUSY);
    assign grant_id   = grant_q;

    // State, owner and rotation pointer; reset makes source 0 win first.
    always_ff @(posedge clk_390) begin
        if (!clk_390_rst_n) begin
            state_q <= ARB_IDLE;
            grant_q <= '0;
            last_q  <= GID_W'(NR_SRC - 1);
        end else begin
            state_q <= state_d;
            if (grant_fire) begin
                grant_q <= pick;
                last_q  <= pick;
            end
        end
    end

    // Next state and the combinational owner mux onto to_net.
    always_comb begin
        state_d  = state_q;
        m_tdata  = '0;
        m_tkeep  = '0;
        m_tuser  = '0;
        m_tlast  = 1'b0;
        m_tvalid = 1'b0;
        s_tready = '0;
        case (state_q)
            ARB_IDLE: begin
                if (grant_fire) state_d = ARB_BUSY;
            end
            ARB_BUSY: begin
                m_tdata            = src_data[grant_q];
                m_tkeep            = src_keep[grant_q];
                m_tuser            = src_user[grant_q];
                m_tlast            = s_tlast[grant_q];
                m_tvalid           = s_tvalid[grant_q];
                s_tready[grant_q]  = m_tready;
                if (s_tvalid[grant_q] && m_tready && s_tlast[grant_q])
                    state_d = ARB_IDLE;
            end
            default: state_d = ARB_IDLE;
        endcase
    end

`ifdef ARB_PKT_STATS_EN
    logic [NR_SRC-1:0][31:0] pkt_cnt_q;

    assign pkt_cnt = pkt_cnt_q;

    // Completed packets per owner and output stall cycles; both wrap freely.
    always_ff @(posedge clk_390) begin
        if (!clk_390_rst_n) begin
            pkt_cnt_q <= '0;
            stall_cnt <= '0;
        end else begin
            if (m_tvalid && m_tready && m_tlast)
                pkt_cnt_q[grant_q] <= pkt_cnt_q[grant_q] + 32'd1;
            if (m_tvalid && !m_tready)
                stall_cnt <= stall_cnt + 32'd1;
        end
    end
`endif

endmodule
